// File: rtl/nn_pkg.sv
// Shared CNN datapath constants: default sample width, C1 feature-map size
// and the pooled (pool1) feature-map size.
package nn_pkg;

  localparam int NN_N = 16;
  localparam int C1_W = 24;
  localparam int C1_H = 24;
  localparam int P1_W = C1_W / 2;
  localparam int P1_H = C1_H / 2;

  // Counter/address width that stays legal for a range of a single value.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer for 2x2 pooling: one write port and one synchronous read
// port whose output holds until the next read.
module pool_line_buf
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_N,
  parameter int DEPTH  = P1_W,
  parameter int AW     = idx_w(P1_W)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/maxpool2x2_c1.sv
// 2x2 stride-2 signed max pooling over a raster-order C1 feature map.
// Optional macro MAXPOOL_RELU_EN clamps negative pooled values to zero.
module maxpool2x2_c1
  import nn_pkg::*;
#(
  parameter int N     = NN_N,
  parameter int IMG_W = C1_W,
  parameter int IMG_H = C1_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                din_vld,
  input  logic signed [N-1:0] din,
  output logic signed [N-1:0] dout,
  output logic                dout_vld,
  output logic                frame_end
);

  localparam int OW = IMG_W / 2;
  localparam int CW = idx_w(IMG_W);
  localparam int RW = idx_w(IMG_H);
  localparam int AW = idx_w(OW);

  function automatic logic signed [N-1:0] smax(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [N-1:0] relu(input logic signed [N-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[N-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic [CW-1:0]       col_cnt;
  logic [RW-1:0]       row_cnt;
  logic signed [N-1:0] pair_p0;
  logic signed [N-1:0] dout_p1;
  logic                vld_p1;
  logic                fe_p1;

  logic                accept;
  logic                odd_col;
  logic                odd_row;
  logic                col_last;
  logic                row_last;
  logic [AW-1:0]       buf_addr;
  logic signed [N-1:0] hmax;
  logic signed [N-1:0] buf_rd;
  logic signed [N-1:0] pool;
  logic                buf_we;
  logic                buf_re;

  assign accept   = ce & din_vld;
  assign odd_col  = col_cnt[0];
  assign odd_row  = row_cnt[0];
  assign col_last = (col_cnt == CW'(IMG_W - 1));
  assign row_last = (row_cnt == RW'(IMG_H - 1));
  assign buf_addr = AW'(col_cnt >> 1);
  assign hmax     = smax(pair_p0, din);
  assign pool     = smax(buf_rd, hmax);

  // Odd rows fetch the stored pair on the even column so the data is ready
  // (and held through any gap) when the odd-column sample arrives.
  assign buf_we = accept & odd_col & ~odd_row;
  assign buf_re = accept & ~odd_col & odd_row;

  pool_line_buf #(
    .DATA_W (N),
    .DEPTH  (OW),
    .AW     (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (hmax),
    .re    (buf_re),
    .raddr (buf_addr),
    .rdata (buf_rd)
  );

  // Stage p0 -> p1: counters, pair register, pooled output register
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      pair_p0 <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      fe_p1   <= 1'b0;
    end else if (ce) begin
      vld_p1 <= 1'b0;
      fe_p1  <= 1'b0;
      if (din_vld) begin
        if (!odd_col) pair_p0 <= din;
        if (odd_col && odd_row) begin
          dout_p1 <= relu(pool);
          vld_p1  <= 1'b1;
          fe_p1   <= col_last & row_last;
        end
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  // A pending strobe is held while ce is low and shown on the next enabled cycle.
  assign dout      = dout_p1;
  assign dout_vld  = vld_p1 & ce;
  assign frame_end = fe_p1 & ce;

endmodule

// File: tb/tb_maxpool2x2_c1.sv
// Self-checking bench for maxpool2x2_c1: a 4x4 instance and a 24x24 instance
// share one input stream; outputs are compared with a frame-level reference model.
module tb_maxpool2x2_c1;

  localparam int N = 16;

  typedef struct {
    int din;
    int vld;
    int dout;
    int fe;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                ce;
  logic                din_vld;
  logic signed [N-1:0] din;
  logic signed [N-1:0] dout4, dout24;
  logic                dv4, dv24, fe4, fe24;

  int tests = 0;
  int fails = 0;

  logic signed [N-1:0] img_q[$];
  logic signed [N-1:0] got4_q[$];
  logic signed [N-1:0] got24_q[$];
  bit                  gfe4_q[$];
  bit                  gfe24_q[$];

  maxpool2x2_c1 #(.N(N), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .din_vld(din_vld), .din(din),
    .dout(dout4), .dout_vld(dv4), .frame_end(fe4)
  );

  maxpool2x2_c1 #(.N(N), .IMG_W(24), .IMG_H(24)) dut24 (
    .clk(clk), .rst(rst), .ce(ce), .din_vld(din_vld), .din(din),
    .dout(dout24), .dout_vld(dv24), .frame_end(fe24)
  );

  always @(negedge clk) begin
    if (dv4) begin
      got4_q.push_back(dout4);
      gfe4_q.push_back(fe4);
    end
    if (dv24) begin
      got24_q.push_back(dout24);
      gfe24_q.push_back(fe24);
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    ce = 1'($urandom_range(0, 1));
    din_vld = 1'b1;
    din = 16'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    ce = 1'b1;
    din_vld = 1'b0;
    got4_q.delete();
    got24_q.delete();
    gfe4_q.delete();
    gfe24_q.delete();
  endtask

  // mode 0: continuous; mode 1: idle cycle before each sample plus random ce-low bursts
  task automatic send_px(input logic signed [N-1:0] v, input int mode);
    if (mode == 1) begin
      ce = 1'b1;
      din_vld = 1'b0;
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        ce = 1'b0;
        din_vld = 1'b1;
        din = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ce = 1'b1;
    din_vld = 1'b1;
    din = v;
    @(posedge clk); #1;
  endtask

  task automatic send_img(input int mode);
    for (int i = 0; i < img_q.size(); i++) send_px(img_q[i], mode);
    din_vld = 1'b0;
  endtask

  task automatic drain();
    ce = 1'b1;
    din_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verify(input int sel, input int w, input int h, input int nf, input string nm);
    logic signed [N-1:0] g[$];
    logic signed [N-1:0] e[$];
    bit                  f[$];
    int                  per;
    int                  n;
    per = (w / 2) * (h / 2);
    if (sel == 4) begin
      g = got4_q;
      f = gfe4_q;
    end else begin
      g = got24_q;
      f = gfe24_q;
    end
    for (int k = 0; k < nf; k++)
      for (int r = 0; r < h; r += 2)
        for (int c = 0; c < w; c += 2) begin
          int b;
          int m;
          b = k * w * h + r * w + c;
          m = imax(imax(int'(img_q[b]), int'(img_q[b + 1])),
                   imax(int'(img_q[b + w]), int'(img_q[b + w + 1])));
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          e.push_back(16'(m));
        end
    chk({nm, "_count"}, g.size(), e.size());
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_dout[%0d]", nm, i), g[i], e[i]);
      chk($sformatf("%s_fe[%0d]", nm, i), f[i], ((i % per) == per - 1) ? 1 : 0);
    end
  endtask

  initial begin
    vec_t tbl[16];
    int   relu_exp;
    tbl = '{'{0, 0, 0, 0},  '{1, 0, 0, 0},  '{2, 0, 0, 0},   '{3, 0, 0, 0},
            '{4, 0, 0, 0},  '{5, 1, 5, 0},  '{6, 0, 5, 0},   '{7, 1, 7, 0},
            '{8, 0, 7, 0},  '{9, 0, 7, 0},  '{10, 0, 7, 0},  '{11, 0, 7, 0},
            '{12, 0, 7, 0}, '{13, 1, 13, 0}, '{14, 0, 13, 0}, '{15, 1, 15, 1}};

    rst = 1'b1;
    ce = 1'b0;
    din_vld = 1'b1;
    din = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout4", dout4, 0);
    chk("rst_vld4", dv4, 0);
    chk("rst_fe4", fe4, 0);
    chk("rst_dout24", dout24, 0);
    chk("rst_vld24", dv24, 0);
    chk("rst_fe24", fe24, 0);

    // 4x4 ramp, continuous: per-cycle check of strobe, value and frame_end
    rst = 1'b0;
    ce = 1'b1;
    din_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      din_vld = 1'b1;
      din = 16'(tbl[k].din);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ramp_vld[%0d]", k), dv4, tbl[k].vld);
      chk($sformatf("ramp_dout[%0d]", k), dout4, tbl[k].dout);
      chk($sformatf("ramp_fe[%0d]", k), fe4, tbl[k].fe);
    end
    din_vld = 1'b0;
    @(posedge clk); #1;

    // same ramp with din_vld gaps and ce-low bursts
    pulse_rst();
    img_q.delete();
    for (int k = 0; k < 16; k++) img_q.push_back(16'(k));
    send_img(1);
    drain();
    verify(4, 4, 4, 1, "gapped_ramp");

    // negative window
    pulse_rst();
    img_q.delete();
    for (int k = 0; k < 16; k++) img_q.push_back(16'($urandom));
    img_q[0] = -16'sd3;
    img_q[1] = -16'sd1;
    img_q[4] = -16'sd7;
    img_q[5] = -16'sd2;
    send_img(0);
    drain();
`ifdef MAXPOOL_RELU_EN
    relu_exp = 0;
`else
    relu_exp = -1;
`endif
    chk("neg_window", (got4_q.size() > 0) ? longint'(got4_q[0]) : 64'sd99999, relu_exp);
    verify(4, 4, 4, 1, "neg_frame");

    // ce low right after an odd-row odd-column sample delays the strobe
    pulse_rst();
    for (int k = 0; k < 5; k++) send_px(16'(k), 0);
    ce = 1'b1;
    din_vld = 1'b1;
    din = 16'sd5;
    @(posedge clk); #1;
    ce = 1'b0;
    din = 16'sd77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ce_hold_vld[%0d]", k), dv4, 0);
    end
    ce = 1'b1;
    din_vld = 1'b0;
    #1;
    chk("ce_release_vld", dv4, 1);
    chk("ce_release_dout", dout4, 5);
    @(posedge clk); #1;
    chk("ce_after_vld", dv4, 0);
    chk("ce_after_dout", dout4, 5);

    // two back-to-back 24x24 frames
    pulse_rst();
    img_q.delete();
    for (int k = 0; k < 2 * 24 * 24; k++) img_q.push_back(16'($urandom));
    send_img(0);
    drain();
    verify(24, 24, 24, 2, "b2b");

    // reset mid-frame, then a full gapped frame
    pulse_rst();
    for (int k = 0; k < 30; k++) send_px(16'($urandom), 0);
    din_vld = 1'b0;
    @(posedge clk); #1;
    chk("partial_count", got24_q.size(), 3);
    pulse_rst();
    @(negedge clk);
    chk("midrst_dout24", dout24, 0);
    chk("midrst_vld24", dv24, 0);
    img_q.delete();
    for (int k = 0; k < 24 * 24; k++) img_q.push_back(16'($urandom));
    send_img(1);
    drain();
    verify(24, 24, 24, 1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_c1.md
MAXPOOL2X2_C1 -- requirements
Module: maxpool2x2_c1

Interface
REQ-001 SHALL have parameter N, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter IMG_W, default 24, input columns; even, >=2.
REQ-003 SHALL have parameter IMG_H, default 24, input rows; even, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port ce  input  1  enable; low freezes all state and outputs.
REQ-007 SHALL have port din_vld  input  1  din valid this cycle, raster order (row-major).
REQ-008 SHALL have port din  input  N  conv-unit output sample.
REQ-009 SHALL have port dout  output  N  pooled sample.
REQ-010 SHALL have port dout_vld  output  1  one-cycle strobe, dout valid.
REQ-011 SHALL have port frame_end  output  1  one-cycle strobe coincident with last pooled sample of frame.

Function
REQ-012 SHALL accept a sample only when ce=1 and din_vld=1; otherwise no counter, buffer or register changes.
REQ-013 SHALL track col_cnt 0..IMG_W-1 and row_cnt 0..IMG_H-1; col_cnt wraps to 0 and row_cnt increments at col_cnt=IMG_W-1; both wrap to 0 after last sample of frame.
REQ-014 SHALL hold the even-column sample in a pair register; on the odd-column sample form hmax = signed max(pair, din).
REQ-015 Even rows (row_cnt[0]=0): SHALL write hmax to line buffer at address col_cnt>>1; no output.
REQ-016 Odd rows: SHALL read line buffer at col_cnt>>1 and register dout = signed max(buffer, hmax) with dout_vld=1 on the cycle after the odd-column sample is accepted (latency 1).
REQ-017 Equal values SHALL yield that value; compare is signed over full N bits.
REQ-018 SHALL produce exactly (IMG_W/2)*(IMG_H/2) dout_vld strobes per frame, in raster order.
REQ-019 frame_end SHALL assert with the dout_vld of output index (IMG_W/2)*(IMG_H/2)-1 only.
REQ-020 dout SHALL hold its last value when dout_vld=0; dout_vld and frame_end SHALL be 0 in any cycle without a new output.
REQ-021 Gaps in din_vld (any length, any position) SHALL NOT alter results.
REQ-022 Back-to-back frames SHALL be supported with no idle cycle between last sample of frame k and first of frame k+1.
REQ-023 When ce=0 in the cycle following an accepted odd-column odd-row sample, dout_vld SHALL be delayed until the first cycle with ce=1.

Reset
REQ-024 On rst=1: col_cnt=0, row_cnt=0, pair register=0, dout=0, dout_vld=0, frame_end=0; line buffer contents need not be cleared.
REQ-025 rst SHALL take priority over ce and din_vld; reset mid-frame discards the partial frame, and the next accepted sample is pixel (0,0).

Configuration
REQ-026 Macro MAXPOOL_RELU_EN: when defined, dout SHALL be clamped to 0 if the pooled value is negative (MSB=1); when undefined, dout SHALL be the raw signed max.

Structure
REQ-027 Package nn_pkg SHALL hold shared constants: default N, C1 output dimensions (24x24), pooled dimensions (12x12).
REQ-028 Line buffer SHALL be sub-module pool_line_buf: IMG_W/2 entries x N bits, one write port and one synchronous-read port.
REQ-029 Counter/compare logic SHALL stay in maxpool2x2_c1; no other sub-modules.

Verification
REQ-030 4x4 frame (IMG_W=IMG_H=4), din=0..15 continuous -> dout 5,7,13,15; frame_end with 15; each dout_vld 1 cycle after the odd-column sample of an odd row.
REQ-031 Same frame with din_vld toggling 1/0 every cycle and random ce=0 cycles -> identical output sequence 5,7,13,15.
REQ-032 Window {-3,-1,-7,-2} (N=16): MAXPOOL_RELU_EN undefined -> dout=0xFFFF (-1); defined -> dout=0.
REQ-033 Two back-to-back 24x24 frames of random data -> 144 outputs each matching a reference model; frame_end on outputs 143 and 287 only.
REQ-034 rst pulsed after 30 samples of a 24x24 frame, then a full frame -> exactly 144 outputs, all correct for the new frame only.
